// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: upstream immediate stream, flush,
// downstream extended-immediate stream and the accepted-item counter.
interface imm_extend_pipe_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int CNT_W = 16
);
   // valid/ready: a transfer happens on a rising clk edge where both are 1;
   // a producer holds valid and its data stable until that edge.
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_imm;
   logic [1:0]       in_mode;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_imm;
   logic [CNT_W-1:0] out_cnt;

   modport master (
      output in_valid, in_imm, in_mode, flush, out_ready,
      input  in_ready, out_valid, out_imm, out_cnt
   );

   modport slave (
      input  in_valid, in_imm, in_mode, flush, out_ready,
      output in_ready, out_valid, out_imm, out_cnt
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Immediate extender followed by a 2-entry skid buffer (main + skid) with a
// registered in_ready and a free-running count of accepted inputs.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   imm_extend_pipe_if.slave   bus,
   output logic [1:0]         dbg_state_o
);

   if (IN_W < 2 || IN_W > 32) begin : g_bad_in_w
      $error("imm_extend_pipe: IN_W must be in 2..32");
   end
   if (OUT_W < IN_W + 2 || OUT_W > 64) begin : g_bad_out_w
      $error("imm_extend_pipe: OUT_W must satisfy IN_W+2 <= OUT_W <= 64");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("imm_extend_pipe: CNT_W must be at least 1");
   end
   if ($bits(bus.in_imm) != IN_W || $bits(bus.out_imm) != OUT_W ||
       $bits(bus.out_cnt) != CNT_W) begin : g_bad_if
      $error("imm_extend_pipe: interface widths do not match module parameters");
   end

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                               input logic [1:0]      mode);
      logic [OUT_W-1:0] sext;
      sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
      case (mode)
         2'b00:   return sext;
         2'b01:   return {{(OUT_W-IN_W){1'b0}}, imm};
         2'b10:   return {imm, {(OUT_W-IN_W){1'b0}}};
         default: return sext << 2;
      endcase
   endfunction

   state_t           state_q;
   logic             in_ready_q;
   logic [OUT_W-1:0] main_q;
   logic [OUT_W-1:0] skid_q;
   logic [CNT_W-1:0] cnt_q;

   logic [OUT_W-1:0] ext_w;
   logic             out_fire_w;
   logic             accept_w;

   assign ext_w      = extend(bus.in_imm, bus.in_mode);
   assign out_fire_w = (state_q != EMPTY) && bus.out_ready;
   // An input offered during a flush cycle is neither stored nor counted.
   assign accept_w   = bus.in_valid && in_ready_q && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
         cnt_q      <= '0;
      end else begin
         if (accept_w) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         in_ready_q <= 1'b1;
         if (bus.flush) begin
            state_q <= EMPTY;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (accept_w) begin
                     main_q  <= ext_w;
                     state_q <= ONE;
                  end
               end
               ONE: begin
                  if (accept_w && !out_fire_w) begin
                     skid_q     <= ext_w;
                     state_q    <= FULL;
                     in_ready_q <= 1'b0;
                  end else if (accept_w && out_fire_w) begin
                     main_q <= ext_w;
                  end else if (out_fire_w) begin
                     state_q <= EMPTY;
                  end
               end
               FULL: begin
                  if (out_fire_w) begin
                     main_q  <= skid_q;
                     state_q <= ONE;
                  end else begin
                     in_ready_q <= 1'b0;
                  end
               end
               default: begin
                  state_q <= EMPTY;
               end
            endcase
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = (state_q != EMPTY);
   assign bus.out_imm   = main_q;
   assign bus.out_cnt   = cnt_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: extension modes, stall/skid ordering,
// back-to-back streaming, flush, asynchronous reset and counter wrap.
module tb_imm_extend_pipe;

   logic clk;
   logic rst_n;
   logic [1:0] dbg_state;
   logic [1:0] dbg_state4;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] exp_q[$];

   imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .CNT_W(16)) bus ();
   imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .CNT_W(4))  bus4 ();

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .dbg_state_o (dbg_state)
   );

   imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus4.slave),
      .dbg_state_o (dbg_state4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [15:0] imm, input logic [1:0] mode);
      bus.in_valid = v;
      bus.in_imm   = imm;
      bus.in_mode  = mode;
   endtask

   logic [15:0] v_imm [5] = '{16'h8004, 16'h8004, 16'h1234, 16'hFFFF, 16'h7FFF};
   logic [1:0]  v_mode[5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
   logic [31:0] v_exp [5] = '{32'hFFFF8004, 32'h00008004, 32'h12340000,
                              32'hFFFFFFFC, 32'h0001FFFC};

   logic [15:0] b_imm [4] = '{16'h0010, 16'h8000, 16'hABCD, 16'h8000};
   logic [1:0]  b_mode[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
   logic [31:0] b_exp [4] = '{32'h00000010, 32'h00008000, 32'hABCD0000, 32'hFFFE0000};

   initial begin
      rst_n = 1'b0;
      drive_in(1'b0, 16'h0, 2'b00);
      bus.flush      = 1'b0;
      bus.out_ready  = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.in_imm    = 16'h0;
      bus4.in_mode   = 2'b00;
      bus4.flush     = 1'b0;
      bus4.out_ready = 1'b1;

      #2;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready),  64'd0);
      check("rst_out_imm",   64'(bus.out_imm),   64'd0);
      check("rst_out_cnt",   64'(bus.out_cnt),   64'd0);

      tick();
      rst_n = 1'b1;
      tick();
      check("rel_in_ready", 64'(bus.in_ready), 64'd1);

      // One item at a time through each extension mode.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_in(1'b1, v_imm[i], v_mode[i]);
         tick();
         drive_in(1'b0, 16'h0, 2'b00);
         check("vec_valid", 64'(bus.out_valid), 64'd1);
         check("vec_imm",   64'(bus.out_imm),   64'(v_exp[i]));
         tick();
         check("vec_drain", 64'(bus.out_valid), 64'd0);
      end
      check("vec_cnt", 64'(bus.out_cnt), 64'd5);

      // Stall: A and B fill main+skid, C waits upstream until drain.
      bus.out_ready = 1'b0;
      drive_in(1'b1, 16'h0001, 2'b00);
      tick();
      check("stall_a_imm", 64'(bus.out_imm), 64'h1);
      drive_in(1'b1, 16'hFFFF, 2'b01);
      tick();
      check("stall_full_ready", 64'(bus.in_ready), 64'd0);
      check("stall_full_state", 64'(dbg_state),    64'd2);
      check("stall_a_hold1",    64'(bus.out_imm),  64'h1);
      drive_in(1'b1, 16'h00AB, 2'b10);
      tick();
      check("stall_a_hold2", 64'(bus.out_imm),   64'h1);
      check("stall_valid",   64'(bus.out_valid), 64'd1);
      check("stall_cnt",     64'(bus.out_cnt),   64'd7);
      bus.out_ready = 1'b1;
      tick();
      check("stall_b_imm",   64'(bus.out_imm),  64'h0000FFFF);
      check("stall_b_ready", 64'(bus.in_ready), 64'd1);
      tick();
      drive_in(1'b0, 16'h0, 2'b00);
      check("stall_c_imm", 64'(bus.out_imm), 64'h00AB0000);
      tick();
      check("stall_empty", 64'(bus.out_valid), 64'd0);
      check("stall_cnt2",  64'(bus.out_cnt),   64'd8);

      // Back-to-back streaming, one result per cycle.
      for (int i = 0; i < 4; i++) exp_q.push_back(64'(b_exp[i]));
      for (int i = 0; i < 4; i++) begin
         drive_in(1'b1, b_imm[i], b_mode[i]);
         tick();
         check("b2b_valid", 64'(bus.out_valid), 64'd1);
         check("b2b_imm",   64'(bus.out_imm),   exp_q.pop_front());
         check("b2b_ready", 64'(bus.in_ready),  64'd1);
         check("b2b_cnt",   64'(bus.out_cnt),   64'(9 + i));
      end
      drive_in(1'b0, 16'h0, 2'b00);
      tick();
      check("b2b_drain", 64'(bus.out_valid), 64'd0);

      // Flush from FULL while an input is offered.
      bus.out_ready = 1'b0;
      drive_in(1'b1, 16'h1111, 2'b00);
      tick();
      drive_in(1'b1, 16'h2222, 2'b00);
      tick();
      check("flush_pre_state", 64'(dbg_state), 64'd2);
      drive_in(1'b1, 16'h3333, 2'b00);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      drive_in(1'b0, 16'h0, 2'b00);
      check("flush_valid", 64'(bus.out_valid), 64'd0);
      check("flush_ready", 64'(bus.in_ready),  64'd1);
      check("flush_cnt",   64'(bus.out_cnt),   64'd14);

      // Asynchronous reset mid-stream, no clock edge needed.
      drive_in(1'b1, 16'h4444, 2'b01);
      tick();
      drive_in(1'b0, 16'h0, 2'b00);
      check("mid_pre_valid", 64'(bus.out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_imm",   64'(bus.out_imm),   64'd0);
      check("mid_rst_ready", 64'(bus.in_ready),  64'd0);
      check("mid_rst_cnt",   64'(bus.out_cnt),   64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rel_ready", 64'(bus.in_ready),  64'd1);
      check("mid_rel_valid", 64'(bus.out_valid), 64'd0);

      // CNT_W=4 counter wraps after 16 accepted inputs.
      bus4.in_valid = 1'b1;
      bus4.in_imm   = 16'h00FF;
      for (int i = 0; i < 15; i++) tick();
      check("wrap_cnt15", 64'(bus4.out_cnt), 64'd15);
      tick();
      check("wrap_cnt16", 64'(bus4.out_cnt), 64'd0);
      tick();
      bus4.in_valid = 1'b0;
      check("wrap_cnt17",  64'(bus4.out_cnt), 64'd1);
      check("wrap_imm",    64'(bus4.out_imm), 64'hFF);
      check("wrap_state",  64'(dbg_state4),   64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width in bits (legal range 2..32).
REQ-002 SHALL have parameter OUT_W, default 32, extended output width in bits (legal: OUT_W >= IN_W+2, OUT_W <= 64).
REQ-003 SHALL have parameter CNT_W, default 16, width of the accepted-item counter.
REQ-004 SHALL provide clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL provide rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL provide in_valid  input  1  upstream has an immediate.
REQ-007 SHALL provide in_ready  output  1  block can accept this cycle.
REQ-008 SHALL provide in_imm  input  IN_W  raw immediate.
REQ-009 SHALL provide in_mode  input  2  extension mode for in_imm.
REQ-010 SHALL provide flush  input  1  synchronous discard of all buffered items.
REQ-011 SHALL provide out_valid  output  1  out_imm holds a result.
REQ-012 SHALL provide out_ready  input  1  downstream accepts this cycle.
REQ-013 SHALL provide out_imm  output  OUT_W  extended immediate.
REQ-014 SHALL provide out_cnt  output  CNT_W  count of items accepted at input since reset.

Function
REQ-015 Modes SHALL compute: 00 sign-extend in_imm to OUT_W; 01 zero-extend; 10 upper: in_imm placed at bits [OUT_W-1:OUT_W-IN_W], lower bits 0; 11 branch: sign-extend then shift left 2, top two bits dropped.
REQ-016 Extension SHALL be computed at input acceptance and registered; stored values are never recomputed.
REQ-017 Handshake: input transfer iff in_valid && in_ready; output transfer iff out_valid && out_ready.
REQ-018 Storage SHALL be a 2-entry skid buffer: main (drives out_imm) and skid.
REQ-019 States: EMPTY (0 held), ONE (main valid), FULL (main+skid valid); out_valid = (state != EMPTY).
REQ-020 in_ready SHALL be registered: 1 in EMPTY and ONE, 0 in FULL; never combinationally dependent on out_ready.
REQ-021 EMPTY + input -> ONE; result visible on out_imm the next cycle (latency 1).
REQ-022 ONE + input, no output -> FULL (new item into skid); ONE + input + output -> ONE (new item into main); ONE + output only -> EMPTY.
REQ-023 FULL + output -> ONE, skid moves to main same edge; FULL without output holds; input ignored in FULL.
REQ-024 out_imm and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-025 Ordering SHALL be strictly first-in first-out; no item duplicated or lost except via flush.
REQ-026 flush SHALL force EMPTY next edge regardless of handshakes that cycle; input offered in a flush cycle is dropped and not counted.
REQ-027 out_cnt SHALL increment by 1 per input transfer, wrapping from 2^CNT_W-1 to 0; unaffected by flush.
REQ-028 Out-of-range parameter combinations SHALL be rejected at elaboration.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force state EMPTY, out_valid=0, in_ready=0, out_imm=0, skid data=0, out_cnt=0.
REQ-030 in_ready SHALL rise to 1 on the first rising clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered items; no partial output after release.

Verification
REQ-032 Defaults, mode 00, in_imm=16'h8004 -> out_imm=32'hFFFF8004 one cycle later; mode 01 -> 32'h00008004.
REQ-033 Mode 10, in_imm=16'h1234 -> 32'h12340000; mode 11, in_imm=16'hFFFF -> 32'hFFFFFFFC, in_imm=16'h7FFF -> 32'h0001FFFC.
REQ-034 out_ready=0, push A then B -> FULL, in_ready=0, C held upstream; raise out_ready -> A, B, C emerge in order, out_imm stable while stalled.
REQ-035 Back-to-back with out_ready=1 -> one result per cycle, in_ready stays 1, out_cnt increments every cycle.
REQ-036 FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_cnt unchanged.
REQ-037 rst_n pulsed low mid-stream -> outputs zero immediately without clock; CNT_W=4 run of 17 inputs -> out_cnt=1.
